// File: rtl/cond_logic.sv
// cond_logic: ARM condition evaluation and predicated commit gating, with the architectural {V,C,N,Z} flag register
module cond_logic #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter bit         NV_PASSES   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic [3:0] flags
);
    logic v, c, n, z, base;

    assign {v, c, n, z} = flags;

    // Conditions come in complementary pairs; cond[0] selects the inverted test
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = n == v;
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        cond_ex = (cond == 4'b1111) ? NV_PASSES : base ^ cond[0];
    end

    assign pc_src    = pcs & cond_ex;
    assign reg_write = reg_w & cond_ex;
    assign mem_write = mem_w & cond_ex;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= RESET_FLAGS;
        end else if (en && cond_ex) begin
            if (flag_w[1]) flags[1:0] <= alu_flags[1:0];
            if (flag_w[0]) flags[3:2] <= alu_flags[3:2];
        end
    end
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed and randomized checks of cond_logic against a flag/condition model
module tb_cond_logic;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [3:0] cond = 4'd0;
    logic [3:0] alu_flags = 4'd0;
    logic [1:0] flag_w = 2'd0;
    logic       pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0;
    logic       pc_src, reg_write, mem_write, cond_ex;
    logic [3:0] flags;
    logic [3:0] mf = 4'd0;
    int checks = 0;
    int failures = 0;

    cond_logic dut (
        .clk(clk), .reset(reset), .en(en), .cond(cond), .alu_flags(alu_flags),
        .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
        .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
        .cond_ex(cond_ex), .flags(flags)
    );

    always #5 clk = ~clk;

    function automatic bit pass(input logic [3:0] cc, input logic [3:0] f);
        bit vv, cf, nn, zz;
        vv = f[3]; cf = f[2]; nn = f[1]; zz = f[0];
        case (cc)
            4'h0: return zz;
            4'h1: return !zz;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return nn;
            4'h5: return !nn;
            4'h6: return vv;
            4'h7: return !vv;
            4'h8: return cf && !zz;
            4'h9: return !cf || zz;
            4'hA: return nn == vv;
            4'hB: return nn != vv;
            4'hC: return !zz && nn == vv;
            4'hD: return zz || nn != vv;
            4'hE: return 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference flag register
    always @(posedge clk or posedge reset) begin
        if (reset) mf <= 4'b0000;
        else if (en && pass(cond, mf)) begin
            if (flag_w[1]) mf[1:0] <= alu_flags[1:0];
            if (flag_w[0]) mf[3:2] <= alu_flags[3:2];
        end
    end

    always @(negedge clk) begin
        chk("flags", flags, mf);
        chk("cond_ex", {3'b0, cond_ex}, {3'b0, pass(cond, mf)});
        chk("pc_src", {3'b0, pc_src}, {3'b0, pcs & pass(cond, mf)});
        chk("reg_write", {3'b0, reg_write}, {3'b0, reg_w & pass(cond, mf)});
        chk("mem_write", {3'b0, mem_write}, {3'b0, mem_w & pass(cond, mf)});
    end

    task automatic drive(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                         input logic p, input logic r, input logic m, input logic e);
        cond = c; alu_flags = af; flag_w = fw; pcs = p; reg_w = r; mem_w = m; en = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] f);
        drive(4'hE, f, 2'b11, 0, 0, 0, 1);
        tick();
    endtask

    initial begin
        drive(4'h0, 4'h0, 2'b00, 0, 0, 0, 1);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_flags", flags, 4'b0000);
        drive(4'hE, 4'b0001, 2'b11, 0, 1, 0, 1);
        #1 chk("al_reg_write", {3'b0, reg_write}, 4'd1);
        tick();
        drive(4'h0, 4'h0, 2'b00, 0, 0, 0, 1);
        #1 chk("eq_after_write", {3'b0, cond_ex}, 4'd1);
        cond = 4'h1;
        #1 chk("ne_after_write", {3'b0, cond_ex}, 4'd0);
        drive(4'h1, 4'b1110, 2'b11, 0, 0, 1, 1);
        #1 chk("ne_squash_mem", {3'b0, mem_write}, 4'd0);
        tick();
        chk("ne_flags_hold", flags, 4'b0001);
        load(4'b0000);
        drive(4'hE, 4'b1111, 2'b10, 0, 0, 0, 1);
        tick();
        chk("nz_only", flags, 4'b0011);
        drive(4'hE, 4'b1100, 2'b01, 0, 0, 0, 1);
        tick();
        chk("vc_only", flags, 4'b1111);
        drive(4'h0, 4'h0, 2'b00, 1, 0, 0, 1);
        #2 reset = 1'b1;
        #1 chk("async_reset_flags", flags, 4'b0000);
        chk("async_reset_pc_src", {3'b0, pc_src}, 4'd0);
        tick();
        reset = 1'b0;
        load(4'b1010);
        drive(4'hE, 4'b0101, 2'b11, 0, 1, 0, 0);
        #1 chk("stall_reg_write", {3'b0, reg_write}, 4'd1);
        tick();
        chk("stall_flags", flags, 4'b1010);
        drive(4'hA, 4'h0, 2'b00, 0, 0, 0, 1);
        #1 chk("ge_nv_set", {3'b0, cond_ex}, 4'd1);
        cond = 4'hB;
        #1 chk("lt_nv_set", {3'b0, cond_ex}, 4'd0);
        load(4'b1011);
        drive(4'hC, 4'h0, 2'b00, 0, 0, 0, 1);
        #1 chk("gt_z_set", {3'b0, cond_ex}, 4'd0);
        for (int f = 0; f < 16; f++) begin
            load(4'(f));
            for (int c = 0; c < 16; c++) begin
                drive(4'(c), 4'h0, 2'b00, 0, 0, 0, 1);
                #1 chk("sweep", {3'b0, cond_ex}, {3'b0, pass(4'(c), 4'(f))});
            end
            tick();
        end
        for (int i = 0; i < 3000; i++) begin
            drive(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                tick();
                reset = 1'b0;
            end else tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
